// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter and its two requesters plus the data memory.
// The slave modport is the arbiter's view of the bus. The master modport is the environment's
// view: the two requesters and the memory, which supplies MEM_RD.
interface mem_port_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          REQ0;
    logic          REQ1;
    logic          WE0;
    logic          WE1;
    logic [AW-1:0] ADDR0;
    logic [AW-1:0] ADDR1;
    logic [DW-1:0] WD0;
    logic [DW-1:0] WD1;
    logic          ACK0;
    logic          ACK1;
    logic [DW-1:0] RD0;
    logic [DW-1:0] RD1;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WD;
    logic          MEM_EN;
    logic [DW-1:0] MEM_RD;
    logic          BUSY;

    modport slave (
        input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WD0, WD1, MEM_RD,
        output ACK0, ACK1, RD0, RD1, MEM_ADDR, MEM_WD, MEM_EN, BUSY
    );

    modport master (
        output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WD0, WD1, MEM_RD,
        input  ACK0, ACK1, RD0, RD1, MEM_ADDR, MEM_WD, MEM_EN, BUSY
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter with power-up clear for a single-port data memory.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing CLR_VAL to address cnt, one word per cycle; BUSY=1
// ST_ARB   | one granted access per cycle, registered ACK/RD next cycle
module mem_port_arbiter #(
    parameter int          DW      = 16,
    parameter int          AW      = 8,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_ARB   = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cnt;
    logic          last;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic          ereq0;
    logic          ereq1;
    logic          gnt0;
    logic          gnt1;

    // A held REQ is masked during its own ACK cycle so it cannot be granted twice.
    assign ereq0 = bus.REQ0 & ~ack0;
    assign ereq1 = bus.REQ1 & ~ack1;

    // State register plus clear counter, round-robin history and registered responses.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            last  <= 1'b1;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            rd0   <= '0;
            rd1   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                cnt <= cnt + 1'b1;
            end
            ack0 <= gnt0;
            ack1 <= gnt1;
            // MEM_RD is still the pre-write word at this edge, giving read-before-write.
            if (gnt0) begin
                rd0  <= bus.MEM_RD;
                last <= 1'b0;
            end
            if (gnt1) begin
                rd1  <= bus.MEM_RD;
                last <= 1'b1;
            end
        end
    end

    // Leave the clear once the top address has been written.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (cnt == {AW{1'b1}}) state_nxt = ST_ARB;
            ST_ARB:   state_nxt = ST_ARB;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // Grant decision and memory-side drive; on a tie the requester not served last wins.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        bus.MEM_EN   = 1'b0;
        bus.MEM_ADDR = '0;
        bus.MEM_WD   = '0;
        case (state)
            ST_CLEAR: begin
                bus.MEM_EN   = 1'b1;
                bus.MEM_ADDR = cnt;
                bus.MEM_WD   = CLR_VAL;
            end
            ST_ARB: begin
                gnt0 = ereq0 & (~ereq1 | last);
                gnt1 = ereq1 & (~ereq0 | ~last);
                if (gnt0) begin
                    bus.MEM_EN   = bus.WE0;
                    bus.MEM_ADDR = bus.ADDR0;
                    bus.MEM_WD   = bus.WD0;
                end else if (gnt1) begin
                    bus.MEM_EN   = bus.WE1;
                    bus.MEM_ADDR = bus.ADDR1;
                    bus.MEM_WD   = bus.WD1;
                end
            end
            default: ;
        endcase
    end

    assign bus.ACK0 = ack0;
    assign bus.ACK1 = ack1;
    assign bus.RD0  = rd0;
    assign bus.RD1  = rd1;
    assign bus.BUSY = (state == ST_CLEAR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: clear sequence, table-driven accesses, hand-written corner
// sequences, reset during an access, and random traffic against a behavioural model.
module tb_mem_port_arbiter;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    mem_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    mem_port_arbiter #(.DW(DW), .AW(AW), .CLR_VAL(16'h0000)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    // Data memory: asynchronous read, synchronous write.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge CLK) if (bus.MEM_EN) mem[bus.MEM_ADDR] <= bus.MEM_WD;
    assign bus.MEM_RD = mem[bus.MEM_ADDR];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        r0;
        logic        w0;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic        r1;
        logic        w1;
        logic [7:0]  a1;
        logic [15:0] d1;
        logic        en;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic        k0;
        logic        k1;
        logic [15:0] q0;
        logic [15:0] q1;
    } vec_t;

    vec_t tv [15];

    // Behavioural reference state for the random phase.
    logic [15:0] shadow [DEPTH];
    logic        m_ack  [2];
    logic [15:0] m_rd   [2];
    int          m_last;
    logic        pend   [2];
    logic        we_r   [2];
    logic [7:0]  ad_r   [2];
    logic [15:0] wd_r   [2];
    int          wcount [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set0(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        bus.REQ0  = r;
        bus.WE0   = w;
        bus.ADDR0 = a;
        bus.WD0   = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        bus.REQ1  = r;
        bus.WE1   = w;
        bus.ADDR1 = a;
        bus.WD1   = d;
    endtask

    task automatic idle();
        set0(1'b0, 1'b0, 8'h00, 16'h0000);
        set1(1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    // Called just after the last reset edge with RST_N already released.
    // Requests are driven during the clear and must be ignored.
    task automatic check_clear();
        for (int k = 0; k < DEPTH; k++) begin
            set0(k < 200, 1'b1, 8'(k), 16'h5555);
            set1(k >= 50 && k < 150, 1'b0, 8'(k), 16'h6666);
            #2;
            chk("clr_busy", bus.BUSY, 1'b1);
            chk("clr_en", bus.MEM_EN, 1'b1);
            chk("clr_addr", bus.MEM_ADDR, k);
            chk("clr_wd", bus.MEM_WD, 16'h0000);
            chk("clr_ack0", bus.ACK0, 1'b0);
            chk("clr_ack1", bus.ACK1, 1'b0);
            tick();
        end
        idle();
        #2;
        chk("post_clr_busy", bus.BUSY, 1'b0);
        chk("post_clr_en", bus.MEM_EN, 1'b0);
        chk("post_clr_ack0", bus.ACK0, 1'b0);
        chk("post_clr_ack1", bus.ACK1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int w;
        logic e0;
        logic e1;

        //          r0    w0    a0     d0        r1    w1    a1     d1        en    addr   wd        k0    k1    q0        q1
        tv[0]  = '{1'b1, 1'b1, 8'h3C, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h3C, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tv[1]  = '{1'b1, 1'b0, 8'h3C, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tv[2]  = '{1'b1, 1'b0, 8'h3C, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h3C, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tv[3]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h01, 16'h1111, 1'b1, 8'h01, 16'h1111, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
        tv[4]  = '{1'b1, 1'b1, 8'h02, 16'h2222, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 8'h02, 16'h2222, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
        tv[5]  = '{1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 8'h02, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        tv[6]  = '{1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h2222};
        tv[7]  = '{1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 8'h02, 16'h0000, 1'b1, 1'b0, 16'h1111, 16'h2222};
        tv[8]  = '{1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b0, 1'b1, 16'h1111, 16'h2222};
        tv[9]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h1111, 16'h2222};
        tv[10] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h2222};
        tv[11] = '{1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 8'h02, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h2222};
        tv[12] = '{1'b1, 1'b0, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b0, 1'b1, 16'h1111, 16'h2222};
        tv[13] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 16'h1111, 16'h2222};
        tv[14] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 16'h1111, 16'h2222};

        // Power-up reset held for two edges, then the full clear.
        idle();
        RST_N = 1'b0;
        tick();
        tick();
        chk("rst_busy", bus.BUSY, 1'b1);
        chk("rst_ack0", bus.ACK0, 1'b0);
        chk("rst_ack1", bus.ACK1, 1'b0);
        chk("rst_rd0", bus.RD0, 16'h0000);
        chk("rst_rd1", bus.RD1, 16'h0000);
        RST_N = 1'b1;
        check_clear();

        // Single write/read, preload, alternating service and true contention.
        for (int i = 0; i < 15; i++) begin
            set0(tv[i].r0, tv[i].w0, tv[i].a0, tv[i].d0);
            set1(tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
            #2;
            chk($sformatf("tv%0d_en", i), bus.MEM_EN, tv[i].en);
            chk($sformatf("tv%0d_addr", i), bus.MEM_ADDR, tv[i].addr);
            chk($sformatf("tv%0d_wd", i), bus.MEM_WD, tv[i].wd);
            chk($sformatf("tv%0d_ack0", i), bus.ACK0, tv[i].k0);
            chk($sformatf("tv%0d_ack1", i), bus.ACK1, tv[i].k1);
            chk($sformatf("tv%0d_rd0", i), bus.RD0, tv[i].q0);
            chk($sformatf("tv%0d_rd1", i), bus.RD1, tv[i].q1);
            tick();
        end

        // Requester 1 held high for 6 cycles, address advanced at each ACK.
        for (int a = 0; a < DEPTH; a++) wcount[a] = 0;
        acks = 0;
        for (int c = 0; c < 7; c++) begin
            if (c < 6) set1(1'b1, 1'b1, 8'(10 + (c + 1) / 2), 16'hA000 + 16'(10 + (c + 1) / 2));
            else       idle();
            #2;
            if (bus.MEM_EN) wcount[bus.MEM_ADDR]++;
            if (bus.ACK1) acks++;
            chk($sformatf("b2b_ack1_c%0d", c), bus.ACK1, (c % 2) == 1);
            tick();
        end
        chk("b2b_ack_count", acks, 3);
        chk("b2b_wr10", wcount[10], 1);
        chk("b2b_wr11", wcount[11], 1);
        chk("b2b_wr12", wcount[12], 1);
        chk("b2b_wr13", wcount[13], 0);
        chk("b2b_mem11", mem[11], 16'hA00B);

        // Read-before-write on address 5.
        set1(1'b1, 1'b1, 8'h05, 16'h1234);
        tick();
        idle();
        tick();
        set1(1'b1, 1'b1, 8'h05, 16'h5678);
        tick();
        idle();
        #2;
        chk("rbw_ack1", bus.ACK1, 1'b1);
        chk("rbw_rd1_old", bus.RD1, 16'h1234);
        tick();
        set1(1'b1, 1'b0, 8'h05, 16'h0000);
        tick();
        idle();
        #2;
        chk("rbw_ack1_rd", bus.ACK1, 1'b1);
        chk("rbw_rd1_new", bus.RD1, 16'h5678);
        tick();

        // Reset lands on the edge that would complete a granted write.
        set0(1'b1, 1'b1, 8'h20, 16'hDEAD);
        #2;
        chk("midrst_grant_en", bus.MEM_EN, 1'b1);
        RST_N = 1'b0;
        tick();
        idle();
        chk("midrst_ack0", bus.ACK0, 1'b0);
        chk("midrst_ack1", bus.ACK1, 1'b0);
        chk("midrst_rd0", bus.RD0, 16'h0000);
        chk("midrst_rd1", bus.RD1, 16'h0000);
        chk("midrst_busy", bus.BUSY, 1'b1);
        RST_N = 1'b1;
        check_clear();

        // Random traffic from a known state: memory cleared, registered outputs zero,
        // requester 1 counts as served last. Both request in the first cycle.
        for (int a = 0; a < DEPTH; a++) shadow[a] = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            m_ack[i] = 1'b0;
            m_rd[i]  = 16'h0000;
            pend[i]  = 1'b0;
        end
        m_last = 1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_ack[i]) pend[i] = 1'b0;
                if (!pend[i] && (cyc == 0 || $urandom_range(0, 3) != 0)) begin
                    pend[i] = 1'b1;
                    we_r[i] = 1'($urandom_range(0, 1));
                    ad_r[i] = 8'($urandom_range(0, 15));
                    wd_r[i] = 16'($urandom);
                end
            end
            if (cyc == 0) ad_r[1] = ad_r[0] ^ 8'h01;
            set0(pend[0], we_r[0], ad_r[0], wd_r[0]);
            set1(pend[1], we_r[1], ad_r[1], wd_r[1]);
            #2;
            chk("rnd_ack0", bus.ACK0, m_ack[0]);
            chk("rnd_ack1", bus.ACK1, m_ack[1]);
            chk("rnd_rd0", bus.RD0, m_rd[0]);
            chk("rnd_rd1", bus.RD1, m_rd[1]);
            e0 = pend[0] && !m_ack[0];
            e1 = pend[1] && !m_ack[1];
            if (e0 && e1)  w = (m_last == 1) ? 0 : 1;
            else if (e0)   w = 0;
            else if (e1)   w = 1;
            else           w = -1;
            if (w >= 0) begin
                chk("rnd_en", bus.MEM_EN, we_r[w]);
                chk("rnd_addr", bus.MEM_ADDR, ad_r[w]);
                chk("rnd_wd", bus.MEM_WD, wd_r[w]);
                m_rd[w] = shadow[ad_r[w]];
                if (we_r[w]) shadow[ad_r[w]] = wd_r[w];
                m_last = w;
            end else begin
                chk("rnd_idle_en", bus.MEM_EN, 1'b0);
                chk("rnd_idle_addr", bus.MEM_ADDR, 8'h00);
            end
            m_ack[0] = (w == 0);
            m_ack[1] = (w == 1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
